ram1_arbiter: RTL and testbench

Sequencer and arbiter for the single external RAM1 SRAM shared by the instruction-fetch port (IF stage) and the data port (MEM stage) of the pipelined CPU. Converts level-held read/write requests into multi-cycle SRAM strobe sequences on ram1EN/ram1OE/ram1WE, drives the tri-state data bus, and produces a stall to freeze PC and IF/ID while either port is waiting. Data port has priority, since the MEM-stage instruction is older.

---
 rtl/ram1_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram1_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram1_arbiter.sv
// Shares RAM1 between fetch and data ports (data first): read 3 cycles, write 4, stall while any port is unserved.
// Optional RAM1_WAIT_EN adds one wait state per access (read RW after R1, write WW after W2).
module ram1_arbiter (
   input  logic        CLK,
   input  logic        RST,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic [15:0] if_rdata,
   output logic        if_valid,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   output logic [15:0] mem_rdata,
   output logic        mem_valid,
   output logic        stall,
   output logic        ram1EN,
   output logic        ram1OE,
   output logic        ram1WE,
   output logic [15:0] ram1Addr,
   inout  wire  [15:0] ram1Data
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      R1   = 3'd1,
      R2   = 3'd2,
      W1   = 3'd3,
      W2   = 3'd4,
      W3   = 3'd5
`ifdef RAM1_WAIT_EN
      , RW = 3'd6,
      WW   = 3'd7
`endif
   } state_t;

   state_t      state;
   state_t      nxt;
   logic        owner_mem;
   logic        if_done;
   logic        mem_done;
   logic        bus_drive;
   logic [15:0] wdata_q;
   logic        mem_pend;
   logic        if_pend;

   assign mem_pend  = (mem_rd | mem_wr) & ~mem_done;
   assign if_pend   = if_req & ~if_done;
   assign stall     = mem_pend | if_pend;
   assign if_valid  = if_done;
   assign mem_valid = mem_done;
   assign ram1Data  = bus_drive ? wdata_q : 16'hzzzz;

   function automatic state_t next_of(input state_t s, input logic mp, input logic mw,
                                      input logic ip);
      next_of = IDLE;
      case (s)
         IDLE: begin
            if (mp)      next_of = mw ? W1 : R1;
            else if (ip) next_of = R1;
            else         next_of = IDLE;
         end
`ifdef RAM1_WAIT_EN
         R1:      next_of = RW;
         RW:      next_of = R2;
         W2:      next_of = WW;
         WW:      next_of = W3;
`else
         R1:      next_of = R2;
         W2:      next_of = W3;
`endif
         W1:      next_of = W2;
         R2:      next_of = IDLE;
         W3:      next_of = IDLE;
         default: next_of = IDLE;
      endcase
   endfunction

   function automatic logic rd_state(input state_t s);
`ifdef RAM1_WAIT_EN
      rd_state = (s == R1) || (s == RW) || (s == R2);
`else
      rd_state = (s == R1) || (s == R2);
`endif
   endfunction

   function automatic logic we_state(input state_t s);
`ifdef RAM1_WAIT_EN
      we_state = (s == W2) || (s == WW);
`else
      we_state = (s == W2);
`endif
   endfunction

   function automatic logic wr_state(input state_t s);
      wr_state = (s == W1) || (s == W3) || we_state(s);
   endfunction

   assign nxt = next_of(state, mem_pend, mem_wr, if_pend);

   // Strobes and bus enable are decoded from the next state so they change cleanly on the edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         owner_mem <= 1'b0;
         if_done   <= 1'b0;
         mem_done  <= 1'b0;
         if_rdata  <= 16'h0000;
         mem_rdata <= 16'h0000;
         ram1EN    <= 1'b1;
         ram1OE    <= 1'b1;
         ram1WE    <= 1'b1;
         ram1Addr  <= 16'h0000;
         wdata_q   <= 16'h0000;
         bus_drive <= 1'b0;
      end else begin
         state     <= nxt;
         ram1EN    <= (nxt == IDLE);
         ram1OE    <= ~rd_state(nxt);
         ram1WE    <= ~we_state(nxt);
         bus_drive <= wr_state(nxt);
         if (state == IDLE && nxt != IDLE) begin
            owner_mem <= mem_pend;
            ram1Addr  <= mem_pend ? mem_addr : if_addr;
            wdata_q   <= mem_wdata;
         end
         if (!stall) begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
         end
         if (state == R2) begin
            if (owner_mem) begin
               mem_rdata <= ram1Data;
               mem_done  <= 1'b1;
            end else begin
               if_rdata  <= ram1Data;
               if_done   <= 1'b1;
            end
         end
         if (state == W3) mem_done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ram1_arbiter.sv
// Directed bench for ram1_arbiter: transaction-level model checked every cycle plus literal scenario checks.
`timescale 1ns/1ps
module tb_ram1_arbiter;

`ifdef RAM1_WAIT_EN
   localparam int RL = 3;
   localparam int WL = 4;
`else
   localparam int RL = 2;
   localparam int WL = 3;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = 16'h0000;
   logic [15:0] if_rdata;
   logic        if_valid;
   logic        mem_rd = 1'b0;
   logic        mem_wr = 1'b0;
   logic [15:0] mem_addr = 16'h0000;
   logic [15:0] mem_wdata = 16'h0000;
   logic [15:0] mem_rdata;
   logic        mem_valid;
   logic        stall;
   logic        ram1EN;
   logic        ram1OE;
   logic        ram1WE;
   logic [15:0] ram1Addr;
   wire  [15:0] ram1Data;

   ram1_arbiter dut (
      .CLK(CLK), .RST(RST),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid), .stall(stall),
      .ram1EN(ram1EN), .ram1OE(ram1OE), .ram1WE(ram1WE),
      .ram1Addr(ram1Addr), .ram1Data(ram1Data)
   );

   always #5 CLK = ~CLK;

   // SRAM: drives the bus while enabled with OE low, stores while WE is low.
   logic [15:0] sram [0:65535];
   logic [15:0] sram_q;
   assign sram_q   = sram[ram1Addr];
   assign ram1Data = (!ram1EN && !ram1OE) ? sram_q : 16'hzzzz;
   initial forever begin
      @(negedge CLK);
      if (RST && !ram1EN && !ram1WE) sram[ram1Addr] = ram1Data;
   end

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;
   int en_falls = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: one access at a time, counted in cycles since it began.
   logic        m_busy = 1'b0, m_write = 1'b0, m_owner = 1'b0, m_ifd = 1'b0, m_memd = 1'b0;
   int          m_phase = 0;
   logic [15:0] m_addr = 16'h0000, m_wdata = 16'h0000, m_ifr = 16'h0000, m_memr = 16'h0000;

   task automatic model_step();
      logic old_if, old_mem, st;
      if (!RST) begin
         m_busy = 1'b0; m_write = 1'b0; m_owner = 1'b0; m_ifd = 1'b0; m_memd = 1'b0;
         m_phase = 0; m_addr = 16'h0000; m_wdata = 16'h0000; m_ifr = 16'h0000; m_memr = 16'h0000;
      end else begin
         old_if  = m_ifd;
         old_mem = m_memd;
         st = ((mem_rd || mem_wr) && !old_mem) || (if_req && !old_if);
         if (!st) begin
            m_ifd  = 1'b0;
            m_memd = 1'b0;
         end
         if (m_busy) begin
            if (m_phase == (m_write ? WL : RL)) begin
               m_busy = 1'b0;
               if (m_write) m_memd = 1'b1;
               else if (m_owner) begin m_memd = 1'b1; m_memr = sram[m_addr]; end
               else begin m_ifd = 1'b1; m_ifr = sram[m_addr]; end
            end else begin
               m_phase++;
            end
         end else if ((mem_rd || mem_wr) && !old_mem) begin
            m_busy = 1'b1; m_phase = 1; m_owner = 1'b1; m_write = mem_wr;
            m_addr = mem_addr; m_wdata = mem_wdata;
         end else if (if_req && !old_if) begin
            m_busy = 1'b1; m_phase = 1; m_owner = 1'b0; m_write = 1'b0; m_addr = if_addr;
         end
      end
   endtask

   initial forever begin
      @(posedge CLK or negedge RST);
      model_step();
   end

   task automatic compare();
      logic es;
      es = ((mem_rd || mem_wr) && !m_memd) || (if_req && !m_ifd);
      chk("stall", 16'(stall), 16'(es));
      chk("ram1EN", 16'(ram1EN), 16'(!m_busy));
      chk("ram1OE", 16'(ram1OE), 16'(!(m_busy && !m_write)));
      chk("ram1WE", 16'(ram1WE), 16'(!(m_busy && m_write && m_phase >= 2 && m_phase <= WL - 1)));
      chk("bus_drive", 16'(dut.bus_drive), 16'(m_busy && m_write));
      if (m_busy && m_write) chk("ram1Data", ram1Data, m_wdata);
      chk("ram1Addr", ram1Addr, m_addr);
      chk("if_valid", 16'(if_valid), 16'(m_ifd));
      chk("mem_valid", 16'(mem_valid), 16'(m_memd));
      chk("if_rdata", if_rdata, m_ifr);
      chk("mem_rdata", mem_rdata, m_memr);
   endtask

   initial forever begin
      @(negedge CLK);
      if (chk_en) compare();
   end

   initial forever begin
      @(negedge ram1EN);
      en_falls++;
   end

   logic        en_a  [0:15];
   logic        oe_a  [0:15];
   logic        we_a  [0:15];
   logic        st_a  [0:15];
   logic        drv_a [0:15];
   logic        iv_a  [0:15];
   logic        mv_a  [0:15];
   logic [15:0] bus_a [0:15];
   logic [15:0] ird_a [0:15];
   logic [15:0] mrd_a [0:15];

   // Records cycles 0..n-1, cycle 0 being the one in which the request is first seen.
   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge CLK);
         en_a[c] = ram1EN; oe_a[c] = ram1OE; we_a[c] = ram1WE; st_a[c] = stall;
         drv_a[c] = dut.bus_drive; iv_a[c] = if_valid; mv_a[c] = mem_valid;
         bus_a[c] = ram1Data; ird_a[c] = if_rdata; mrd_a[c] = mem_rdata;
      end
   endtask

   task automatic drop_all();
      @(posedge CLK); #1;
      if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      sram[16'h0010] = 16'h0800;
      sram[16'h0020] = 16'h1234;
      sram[16'h0005] = 16'hA5A5;

      repeat (2) @(posedge CLK);
      #1;
      chk("reset_en", 16'(ram1EN), 16'h0001);
      chk("reset_oe", 16'(ram1OE), 16'h0001);
      chk("reset_we", 16'(ram1WE), 16'h0001);
      chk("reset_addr", ram1Addr, 16'h0000);
      chk("reset_valids", {14'd0, if_valid, mem_valid}, 16'h0000);
      chk("reset_rdata", if_rdata | mem_rdata, 16'h0000);
      chk("reset_stall", 16'(stall), 16'h0000);
      @(negedge CLK) RST = 1'b1;
      @(posedge CLK); #1 chk_en = 1'b1;
      repeat (2) @(posedge CLK);
      #1;

      // Fetch only
      if_req = 1'b1; if_addr = 16'h0010;
      run(RL + 2);
      chk("fetch_oe_c0", 16'(oe_a[0]), 16'h0001);
      for (int c = 1; c <= RL; c++) chk("fetch_oe_low", 16'(oe_a[c]), 16'h0000);
      chk("fetch_oe_after", 16'(oe_a[RL + 1]), 16'h0001);
      chk("fetch_valid", 16'(iv_a[RL + 1]), 16'h0001);
      chk("fetch_rdata", ird_a[RL + 1], 16'h0800);
      chk("fetch_stall_end", 16'(st_a[RL + 1]), 16'h0000);
      drop_all();
      chk("fetch_valid_clr", 16'(if_valid), 16'h0000);

      // Write
      mem_wr = 1'b1; mem_addr = 16'h4000; mem_wdata = 16'hBEEF;
      run(WL + 2);
      for (int c = 0; c <= WL + 1; c++)
         chk("write_we", 16'(we_a[c]), 16'((c >= 2 && c <= WL - 1) ? 1'b0 : 1'b1));
      for (int c = 1; c <= WL; c++) chk("write_bus", bus_a[c], 16'hBEEF);
      chk("write_bus_z", 16'(drv_a[WL + 1]), 16'h0000);
      chk("write_valid", 16'(mv_a[WL + 1]), 16'h0001);
      chk("write_sram", sram[16'h4000], 16'hBEEF);
      drop_all();

      // Contention: data read and fetch together
      en_falls = 0;
      mem_rd = 1'b1; mem_addr = 16'h0020; if_req = 1'b1; if_addr = 16'h0005;
      run(2 * RL + 3);
      for (int c = 0; c <= 2 * RL + 1; c++) chk("cont_stall", 16'(st_a[c]), 16'h0001);
      chk("cont_stall_end", 16'(st_a[2 * RL + 2]), 16'h0000);
      chk("cont_mem_first", {15'd0, mv_a[RL + 1]} | {14'd0, iv_a[RL + 1], 1'b0}, 16'h0001);
      chk("cont_mem_rdata", mrd_a[2 * RL + 2], 16'h1234);
      chk("cont_if_rdata", ird_a[2 * RL + 2], 16'hA5A5);
      chk("cont_if_valid", 16'(iv_a[2 * RL + 2]), 16'h0001);
      chk("cont_accesses", 16'(en_falls), 16'h0002);
      drop_all();

      // Write followed by fetch of the same word: bus turnaround
      mem_wr = 1'b1; mem_addr = 16'h0200; mem_wdata = 16'h0F0F; if_req = 1'b1; if_addr = 16'h0200;
      run(WL + RL + 3);
      chk("turn_idle_z", 16'(drv_a[WL + 1]), 16'h0000);
      chk("turn_idle_oe", 16'(oe_a[WL + 1]), 16'h0001);
      chk("turn_oe_low", 16'(oe_a[WL + 2]), 16'h0000);
      chk("turn_rdata", ird_a[WL + RL + 2], 16'h0F0F);
      chk("turn_stall_end", 16'(st_a[WL + RL + 2]), 16'h0000);
      drop_all();

      // Reset in the middle of a write
      mem_wr = 1'b1; mem_addr = 16'h0100; mem_wdata = 16'h5555;
      run(3);
      chk("rst_we_pulse", 16'(we_a[2]), 16'h0000);
      #1 chk_en = 1'b0;
      RST = 1'b0;
      #1;
      chk("rst_we", 16'(ram1WE), 16'h0001);
      chk("rst_en", 16'(ram1EN), 16'h0001);
      chk("rst_bus_z", 16'(dut.bus_drive), 16'h0000);
      chk("rst_valids", {14'd0, if_valid, mem_valid}, 16'h0000);
      chk("rst_rdata", if_rdata | mem_rdata, 16'h0000);
      mem_wr = 1'b0;
      @(negedge CLK) RST = 1'b1;
      @(posedge CLK); #1 chk_en = 1'b1;

      // No requests: idle
      run(3);
      for (int c = 0; c < 3; c++) begin
         chk("idle_strobes", {13'd0, en_a[c], oe_a[c], we_a[c]}, 16'h0007);
         chk("idle_stall", 16'(st_a[c]), 16'h0000);
      end

      @(posedge CLK); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
